// File: rtl/fpu_round_arb_if.sv
// Bundles the requester and result handshake buses of the shared round/normalize unit.
// slave: the arbiter side. master: the side that drives requests and consumes results.
// Widths follow the parameters, so instantiate this with the same values as the arbiter.
interface fpu_round_arb_if #(
   parameter int DATA_W = 24,
   parameter int EXP_W  = 8,
   parameter int N_REQ  = 2
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0]            req_ready;
   logic [N_REQ*EXP_W-1:0]      req_exponent;
   logic [N_REQ*(DATA_W+3)-1:0] req_mantissa;
   logic                        out_valid;
   logic                        out_ready;
   logic [EXP_W-1:0]            out_exponent;
   logic [DATA_W-1:0]           out_mantissa;
   logic [ID_W-1:0]             out_id;

   modport slave (
      input  req_valid, req_exponent, req_mantissa, out_ready,
      output req_ready, out_valid, out_exponent, out_mantissa, out_id
   );

   modport master (
      output req_valid, req_exponent, req_mantissa, out_ready,
      input  req_ready, out_valid, out_exponent, out_mantissa, out_id
   );
endinterface

// File: rtl/fpu_round_arb.sv
// Shared round-to-nearest-even + renormalize stage arbitrated between N_REQ FPU producers.
// Latency: one cycle from grant to out_valid; one result per cycle while out_ready is high.
// Backpressure: a stalled result holds out_* stable and withholds every req_ready.
// FPU_RND_ARB_FIXED_PRIO_EN: when defined, the lowest valid index always wins (no RR pointer).
module fpu_round_arb #(
   parameter int DATA_W = 24,
   parameter int EXP_W  = 8,
   parameter int N_REQ  = 2
) (
   input logic             clk,
   input logic             rst,
   fpu_round_arb_if.slave  bus
);
   localparam int ID_W = $clog2(N_REQ);
   localparam int MW   = DATA_W + 3;
   localparam int LZ_W = $clog2(DATA_W);

   logic                out_valid_q, out_valid_d;
   logic [EXP_W-1:0]    out_exp_q,   out_exp_d;
   logic [DATA_W-1:0]   out_man_q,   out_man_d;
   logic [ID_W-1:0]     out_id_q,    out_id_d;

   logic                slot_free;
   logic                grant_vld;
   logic [ID_W-1:0]     grant_id;
   logic                found;
   logic [N_REQ-1:0]    req_ready_c;

   logic [MW-1:0]       sel_man;
   logic [EXP_W-1:0]    sel_exp;
   logic                rnd;
   logic [DATA_W-1:0]   rounded;
   logic [LZ_W-1:0]     lz;
   logic [DATA_W-1:0]   norm_man;
   logic [EXP_W-1:0]    norm_exp;

`ifndef FPU_RND_ARB_FIXED_PRIO_EN
   logic [ID_W-1:0]     last_q, last_d;
`endif

   // A new result may be written when the register is empty or being drained this cycle.
   assign slot_free = ~out_valid_q | bus.out_ready;

   // Pick the winning requester: RR scan starting after the last grant, or lowest index.
   always_comb begin
      grant_id = '0;
      found    = 1'b0;
`ifdef FPU_RND_ARB_FIXED_PRIO_EN
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (bus.req_valid[k]) begin
            found    = 1'b1;
            grant_id = ID_W'(k);
         end
      end
`else
      for (int k = 1; k <= N_REQ; k++) begin
         if (!found && bus.req_valid[(int'(last_q) + k) % N_REQ]) begin
            found    = 1'b1;
            grant_id = ID_W'((int'(last_q) + k) % N_REQ);
         end
      end
`endif
   end

   // Grant is suppressed during reset so no request is consumed while the unit is held.
   assign grant_vld = slot_free & found & ~rst;

   // One-hot ready back to the granted requester only.
   always_comb begin
      req_ready_c = '0;
      if (grant_vld) begin
         req_ready_c[grant_id] = 1'b1;
      end
   end

   // Select the granted requester's operand fields.
   always_comb begin
      sel_man = '0;
      sel_exp = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            sel_man = bus.req_mantissa[i*MW +: MW];
            sel_exp = bus.req_exponent[i*EXP_W +: EXP_W];
         end
      end
   end

   // Round to nearest even on the 3 guard bits; a carry out of the top simply wraps.
   always_comb begin
      rnd     = sel_man[2] & (sel_man[3] | (|sel_man[1:0]));
      rounded = sel_man[MW-1:3] + DATA_W'(rnd);
   end

   // Leading-zero count; an all-zero value saturates at DATA_W-1 and is not special-cased.
   always_comb begin
      lz = LZ_W'(DATA_W - 1);
      for (int i = 0; i < DATA_W; i++) begin
         if (rounded[i]) begin
            lz = LZ_W'(DATA_W - 1 - i);
         end
      end
      norm_man = rounded << lz;
      norm_exp = sel_exp - EXP_W'(lz);
   end

   // Result register next state: load on grant, clear valid on an idle drain, else hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_exp_d   = out_exp_q;
      out_man_d   = out_man_q;
      out_id_d    = out_id_q;
      if (slot_free) begin
         out_valid_d = grant_vld;
      end
      if (grant_vld) begin
         out_exp_d = norm_exp;
         out_man_d = norm_man;
         out_id_d  = grant_id;
      end
   end

`ifndef FPU_RND_ARB_FIXED_PRIO_EN
   // Pointer advances only when a grant is issued.
   always_comb begin
      last_d = last_q;
      if (grant_vld) begin
         last_d = grant_id;
      end
   end

   // RR pointer register; reset to N_REQ-1 so requester 0 is first in line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= ID_W'(N_REQ - 1);
      end else begin
         last_q <= last_d;
      end
   end
`endif

   // Output result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_exp_q   <= '0;
         out_man_q   <= '0;
         out_id_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_exp_q   <= out_exp_d;
         out_man_q   <= out_man_d;
         out_id_q    <= out_id_d;
      end
   end

   assign bus.req_ready    = req_ready_c;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_exponent = out_exp_q;
   assign bus.out_mantissa = out_man_q;
   assign bus.out_id       = out_id_q;

endmodule

// File: tb/tb_fpu_round_arb.sv
// Directed bench for fpu_round_arb (DATA_W=24, EXP_W=8, N_REQ=2).
// Covers reset, rounding, renormalization, arbitration order, backpressure and async reset.
// Expected values are hand-computed constants.
module tb_fpu_round_arb;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   fpu_round_arb_if #(.DATA_W(24), .EXP_W(8), .N_REQ(2)) bus ();

   fpu_round_arb #(.DATA_W(24), .EXP_W(8), .N_REQ(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Result held after the fairness sequence differs between arbitration modes.
`ifdef FPU_RND_ARB_FIXED_PRIO_EN
   localparam logic       HOLD_ID  = 1'b0;
   localparam logic [23:0] HOLD_MAN = 24'h800002;
   localparam logic [7:0]  HOLD_EXP = 8'h80;
`else
   localparam logic       HOLD_ID  = 1'b1;
   localparam logic [23:0] HOLD_MAN = 24'h800000;
   localparam logic [7:0]  HOLD_EXP = 8'hF9;
`endif

   task automatic set_req(input int i, input logic [7:0] e, input logic [26:0] m);
      bus.req_exponent[i*8 +: 8]   = e;
      bus.req_mantissa[i*27 +: 27] = m;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid = 2'b11;
      bus.out_ready = 1'b1;
      repeat (2) tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.out_mantissa !== 24'h0) begin errors++; $display("FAIL reset_man: got %h want 000000", bus.out_mantissa); end
      checks++; if (bus.out_exponent !== 8'h0) begin errors++; $display("FAIL reset_exp: got %h want 00", bus.out_exponent); end
      checks++; if (bus.out_id !== 1'b0) begin errors++; $display("FAIL reset_id: got %b want 0", bus.out_id); end
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", bus.req_ready); end
      bus.req_valid = 2'b00;
      rst = 1'b0;
   endtask

   task automatic test_single();
      set_req(0, 8'h80, {24'h800001, 3'b100});
      bus.req_valid = 2'b01;
      bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", bus.req_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
      checks++; if (bus.out_mantissa !== 24'h800002) begin errors++; $display("FAIL single_man: got %h want 800002", bus.out_mantissa); end
      checks++; if (bus.out_exponent !== 8'h80) begin errors++; $display("FAIL single_exp: got %h want 80", bus.out_exponent); end
      checks++; if (bus.out_id !== 1'b0) begin errors++; $display("FAIL single_id: got %b want 0", bus.out_id); end
   endtask

   task automatic test_tie_even();
      set_req(0, 8'h40, {24'h800000, 3'b100});
      tick();
      checks++; if (bus.out_mantissa !== 24'h800000) begin errors++; $display("FAIL tie_down_man: got %h want 800000", bus.out_mantissa); end
      checks++; if (bus.out_exponent !== 8'h40) begin errors++; $display("FAIL tie_down_exp: got %h want 40", bus.out_exponent); end
      set_req(0, 8'h40, {24'h800000, 3'b101});
      tick();
      checks++; if (bus.out_mantissa !== 24'h800001) begin errors++; $display("FAIL tie_up_man: got %h want 800001", bus.out_mantissa); end
   endtask

   task automatic test_renorm();
      set_req(0, 8'h20, {24'h000100, 3'b000});
      tick();
      checks++; if (bus.out_mantissa !== 24'h800000) begin errors++; $display("FAIL renorm_man: got %h want 800000", bus.out_mantissa); end
      checks++; if (bus.out_exponent !== 8'h11) begin errors++; $display("FAIL renorm_exp: got %h want 11", bus.out_exponent); end
      // Zero input: lz saturates at 23, exponent wraps 05-17 = EE.
      set_req(0, 8'h05, 27'h0);
      tick();
      checks++; if (bus.out_mantissa !== 24'h000000) begin errors++; $display("FAIL zero_man: got %h want 000000", bus.out_mantissa); end
      checks++; if (bus.out_exponent !== 8'hEE) begin errors++; $display("FAIL zero_exp: got %h want EE", bus.out_exponent); end
      // Rounding carry wraps to zero: exponent 80-17 = 69.
      set_req(0, 8'h80, {24'hFFFFFF, 3'b100});
      tick();
      checks++; if (bus.out_mantissa !== 24'h000000) begin errors++; $display("FAIL wrap_man: got %h want 000000", bus.out_mantissa); end
      checks++; if (bus.out_exponent !== 8'h69) begin errors++; $display("FAIL wrap_exp: got %h want 69", bus.out_exponent); end
      bus.req_valid = 2'b00;
      tick();
   endtask

   task automatic test_fairness();
      logic [1:0]  want_rdy;
      logic        want_id;
      logic [23:0] want_man;
      rst = 1'b1;
      #1;
      rst = 1'b0;
      set_req(0, 8'h80, {24'h800001, 3'b100});
      set_req(1, 8'h10, {24'h000001, 3'b000});
      bus.req_valid = 2'b11;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
`ifdef FPU_RND_ARB_FIXED_PRIO_EN
         want_id = 1'b0;
`else
         want_id = k[0];
`endif
         want_rdy = want_id ? 2'b10 : 2'b01;
         want_man = want_id ? 24'h800000 : 24'h800002;
         #1;
         checks++; if (bus.req_ready !== want_rdy) begin errors++; $display("FAIL fair_ready[%0d]: got %b want %b", k, bus.req_ready, want_rdy); end
         tick();
         checks++; if (bus.out_id !== want_id) begin errors++; $display("FAIL fair_id[%0d]: got %b want %b", k, bus.out_id, want_id); end
         checks++; if (bus.out_mantissa !== want_man) begin errors++; $display("FAIL fair_man[%0d]: got %h want %h", k, bus.out_mantissa, want_man); end
      end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 00", k, bus.req_ready); end
         tick();
         checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== HOLD_ID || bus.out_mantissa !== HOLD_MAN || bus.out_exponent !== HOLD_EXP)
            begin errors++; $display("FAIL bp_hold[%0d]: got v=%b id=%b m=%h e=%h want v=1 id=%b m=%h e=%h", k, bus.out_valid, bus.out_id, bus.out_mantissa, bus.out_exponent, HOLD_ID, HOLD_MAN, HOLD_EXP); end
      end
      bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bp_release_ready: got %b want 01", bus.req_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 1'b0 || bus.out_mantissa !== 24'h800002)
         begin errors++; $display("FAIL bp_drain_grant: got v=%b id=%b m=%h want v=1 id=0 m=800002", bus.out_valid, bus.out_id, bus.out_mantissa); end
      bus.req_valid = 2'b00;
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_drain_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.out_mantissa !== 24'h800002) begin errors++; $display("FAIL idle_drain_hold: got %h want 800002", bus.out_mantissa); end
   endtask

   task automatic test_reset_midop();
      // Grant requester 0 so the RR pointer would favour requester 1 next.
      bus.req_valid = 2'b01;
      bus.out_ready = 1'b1;
      tick();
      bus.req_valid = 2'b00;
      bus.out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
      bus.req_valid = 2'b11;
      bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL midrst_ready: got %b want 00", bus.req_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_nogrant: got %b want 0", bus.out_valid); end
      rst = 1'b0;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL postrst_ready: got %b want 01", bus.req_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 1'b0)
         begin errors++; $display("FAIL postrst_grant: got v=%b id=%b want v=1 id=0", bus.out_valid, bus.out_id); end
      bus.req_valid = 2'b00;
   endtask

   initial begin
      rst              = 1'b1;
      bus.req_valid    = '0;
      bus.req_exponent = '0;
      bus.req_mantissa = '0;
      bus.out_ready    = 1'b0;
      test_reset();
      test_single();
      test_tie_even();
      test_renorm();
      test_fairness();
      test_backpressure();
      test_reset_midop();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
